uart_irq_status: RTL and testbench
==================================

Name: uart_irq_status

Overview:
- Read-direction companion to the UART control-register write block.
- Collects event pulses and FIFO levels from the UART core into a sticky interrupt status register (ISR).
- Keeps an interrupt mask register (IMR), written through separate enable and disable strobes, and drives a registered interrupt line.
- Serves a register-bus read port that returns IMR, ISR, live UART state and the FIFO counts.

Parameters:
- FIFO_DEPTH, 16'd64, depth of the RX and TX FIFOs, used for the full flags
- TOUT_BITS, 8'd32, number of idle bit-ticks before the RX timeout event
- IRQ_W, 16, width of IMR, ISR and the read data

Ports:
- clk  in  1  system clock
- rst  in  1  synchronous active-low reset
- p_IerWe_i  in  1  IMR enable write strobe: sets IMR bits where WrData_i=1
- p_IdrWe_i  in  1  IMR disable write strobe: clears IMR bits where WrData_i=1
- p_IsrWe_i  in  1  ISR write-one-to-clear strobe
- WrData_i  in  16  write data
- p_Re_i  in  1  read strobe
- RdAddr_i  in  3  read address
- RdData_o  out  16  read data
- p_RdValid_o  out  1  one-cycle pulse, read data valid
- RxFifoCount_i  in  16  RX FIFO fill level
- TxFifoCount_i  in  16  TX FIFO fill level
- RxTriggerLevel_i  in  16  RX trigger level
- TxTriggerLevel_i  in  16  TX trigger level
- p_RxByte_i  in  1  one pulse per received byte
- p_BitTick_i  in  1  one pulse per bit period
- p_RxOverflow_i  in  1  RX overflow event pulse
- p_ParityErr_i  in  1  parity error event pulse
- p_FrameErr_i  in  1  frame error event pulse
- InterruptMask_o  out  16  IMR
- InterruptState_o  out  16  ISR
- p_Irq_o  out  1  interrupt request

Behaviour:
- Reset (synchronous, rst=0 sampled at the clk edge):
  - IMR=0, ISR=0, RdData_o=0, p_RdValid_o=0, p_Irq_o=0.
  - Timeout counter=0, timeout armed=0.
  - Edge-detect history: RTRIG=0, TTRIG=1, TXEMPTY=1, so no spurious interrupt after reset.
- Level conditions:
  - RTRIG condition: RxTriggerLevel_i!=0 and RxFifoCount_i>=RxTriggerLevel_i.
  - TTRIG condition: TxFifoCount_i<TxTriggerLevel_i.
  - TXEMPTY condition: TxFifoCount_i==0.
  - All comparisons are unsigned, 16-bit.
- ISR bit map:
  - [0] RTRIG, rising edge of the RTRIG condition.
  - [1] TTRIG, rising edge of the TTRIG condition.
  - [2] RXOVR, set by p_RxOverflow_i.
  - [3] PARE, set by p_ParityErr_i.
  - [4] FRAME, set by p_FrameErr_i.
  - [5] TXEMPTY, rising edge of the TXEMPTY condition.
  - [6] TOUT, RX timeout.
  - [15:7] reserved: always 0, writes ignored.
- ISR update each cycle: ISR <= (ISR & ~clr) | set.
  - An event and a clear of the same bit in the same cycle leaves the bit set (event wins).
  - Events are registered one cycle after the input pulse or edge.
- IMR update:
  - IMR <= (IMR | (ier ? WrData_i : 0)) & ~(idr ? WrData_i : 0).
  - Enable and disable of the same bit in the same cycle leaves it disabled (disable wins).
  - Bits [15:7] stay 0.
- p_Irq_o is registered: |(ISR & IMR), evaluated from the current register values, so it lags the ISR/IMR change by 1 cycle.
- RX timeout:
  - Counter clears on p_RxByte_i or when RxFifoCount_i==0.
  - Otherwise it increments on p_BitTick_i, saturating at TOUT_BITS.
  - p_RxByte_i sets armed=1.
  - When armed=1 and the counter reaches TOUT_BITS: set ISR[6] once and clear armed. It does not retrigger until the next byte.
  - p_RxByte_i and p_BitTick_i in the same cycle: the clear wins.
- Read:
  - Address is sampled when p_Re_i=1; RdData_o and p_RdValid_o=1 appear the next cycle (latency 1).
  - RdData_o holds its value afterwards; p_RdValid_o=0 when there is no read.
  - Back-to-back reads are supported, one per cycle.
- Address map:
  - 0 IMR.
  - 1 ISR (value before this cycle's update).
  - 2 UartState: bit0 RxEmpty, bit1 RxFull (count==FIFO_DEPTH), bit2 TxEmpty, bit3 TxFull, bit4 RTRIG condition, bit5 armed; other bits 0.
  - 3 RxFifoCount_i.
  - 4 TxFifoCount_i.
  - 5-7 read 0.
- Reset asserted mid-read: p_RdValid_o=0 on the next cycle; the pending read is dropped.

Optional Feature:
- Macro ISR_READ_CLEAR_EN.
- Defined:
  - A read of address 1 clears exactly the ISR bits returned by that read, in the same update as a W1C clear.
  - Events arriving in that cycle still set their bits (event wins).
- Undefined: reads have no side effects; ISR is cleared only through p_IsrWe_i.

Test Plan:
1. Reset, then read addresses 0, 1, 2 with RxFifoCount_i=0 and TxFifoCount_i=0 -> data 0x0000, 0x0000, 0x0005; p_Irq_o=0; p_RdValid_o pulses one cycle after each p_Re_i.
2. IER WrData_i=0x0008, then a p_ParityErr_i pulse -> ISR=0x0008 one cycle later, p_Irq_o=1 one cycle after that. W1C 0x0008 -> ISR=0; p_Irq_o=0 one cycle later.
3. Same cycle: p_FrameErr_i and W1C 0x0010 -> ISR[4]=1. Same cycle: IER and IDR both 0x0001 -> IMR[0]=0.
4. RxTriggerLevel_i=4, RxFifoCount_i steps 3->4->5 -> ISR[0] is set once on the 3->4 step only. TxFifoCount_i 1->0 -> ISR[5]=1.
5. TOUT_BITS=32, RxFifoCount_i=1, one p_RxByte_i, then 32 p_BitTick_i pulses -> ISR[6] sets after the 32nd tick; 40 more ticks do not retrigger. A p_RxByte_i at tick 31 restarts the count.
6. With ISR_READ_CLEAR_EN: ISR=0x0024, read address 1 -> RdData_o=0x0024, then ISR=0. An overflow pulse in the read cycle -> ISR=0x0004 afterwards.

Source files
------------

// File: rtl/uart_irq_status.sv
// UART interrupt status/mask block with a latency-1 register read port.
// Optional ISR_READ_CLEAR_EN: reading address 1 clears the ISR bits it returns.
module uart_irq_status #(
  parameter logic [15:0] FIFO_DEPTH = 16'd64,
  parameter logic [7:0]  TOUT_BITS  = 8'd32,
  parameter int unsigned IRQ_W      = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             p_IerWe_i,
  input  logic             p_IdrWe_i,
  input  logic             p_IsrWe_i,
  input  logic [IRQ_W-1:0] WrData_i,
  input  logic             p_Re_i,
  input  logic [2:0]       RdAddr_i,
  output logic [IRQ_W-1:0] RdData_o,
  output logic             p_RdValid_o,
  input  logic [15:0]      RxFifoCount_i,
  input  logic [15:0]      TxFifoCount_i,
  input  logic [15:0]      RxTriggerLevel_i,
  input  logic [15:0]      TxTriggerLevel_i,
  input  logic             p_RxByte_i,
  input  logic             p_BitTick_i,
  input  logic             p_RxOverflow_i,
  input  logic             p_ParityErr_i,
  input  logic             p_FrameErr_i,
  output logic [IRQ_W-1:0] InterruptMask_o,
  output logic [IRQ_W-1:0] InterruptState_o,
  output logic             p_Irq_o
);

  localparam int unsigned CNT_W = 8;
  localparam logic [IRQ_W-1:0] ISR_MASK = IRQ_W'(7'h7F);

  logic [IRQ_W-1:0] r_imr;
  logic [IRQ_W-1:0] r_isr;
  logic [IRQ_W-1:0] r_rd_data;
  logic             r_rd_valid;
  logic             r_irq;
  logic [CNT_W-1:0] r_cnt;
  logic             r_armed;
  logic             r_rtrig_d;
  logic             r_ttrig_d;
  logic             r_txempty_d;

  logic             w_rtrig;
  logic             w_ttrig;
  logic             w_txempty;
  logic [CNT_W-1:0] w_cnt_nxt;
  logic             w_armed_nxt;
  logic             w_tout_evt;
  logic [IRQ_W-1:0] w_set;
  logic [IRQ_W-1:0] w_clr;
  logic [IRQ_W-1:0] w_isr_nxt;
  logic [IRQ_W-1:0] w_imr_nxt;
  logic [5:0]       w_state;
  logic [IRQ_W-1:0] w_rd_mux;

  // FIFO level conditions feeding the edge detectors
  always_comb begin
    w_rtrig   = (RxTriggerLevel_i != 16'd0) && (RxFifoCount_i >= RxTriggerLevel_i);
    w_ttrig   = TxFifoCount_i < TxTriggerLevel_i;
    w_txempty = TxFifoCount_i == 16'd0;
  end

  // RX idle timeout: fires once per armed byte, byte clear beats a tick
  always_comb begin
    w_cnt_nxt = r_cnt;
    if (p_RxByte_i || (RxFifoCount_i == 16'd0)) begin
      w_cnt_nxt = '0;
    end else if (p_BitTick_i && (r_cnt < TOUT_BITS)) begin
      w_cnt_nxt = r_cnt + CNT_W'(1);
    end
    w_tout_evt  = r_armed && !p_RxByte_i && (w_cnt_nxt == TOUT_BITS);
    w_armed_nxt = r_armed;
    if (p_RxByte_i) begin
      w_armed_nxt = 1'b1;
    end else if (w_tout_evt) begin
      w_armed_nxt = 1'b0;
    end
  end

  // ISR/IMR next state; events beat clears, disables beat enables
  always_comb begin
    w_set    = '0;
    w_set[0] = w_rtrig & ~r_rtrig_d;
    w_set[1] = w_ttrig & ~r_ttrig_d;
    w_set[2] = p_RxOverflow_i;
    w_set[3] = p_ParityErr_i;
    w_set[4] = p_FrameErr_i;
    w_set[5] = w_txempty & ~r_txempty_d;
    w_set[6] = w_tout_evt;
    w_clr    = p_IsrWe_i ? WrData_i : '0;
`ifdef ISR_READ_CLEAR_EN
    if (p_Re_i && (RdAddr_i == 3'd1)) begin
      w_clr = w_clr | r_isr;
    end
`endif
    w_isr_nxt = ((r_isr & ~w_clr) | w_set) & ISR_MASK;
    w_imr_nxt = ((r_imr | (p_IerWe_i ? WrData_i : '0)) &
                 ~(p_IdrWe_i ? WrData_i : '0)) & ISR_MASK;
  end

  // Read mux
  always_comb begin
    w_state = {r_armed, w_rtrig, (TxFifoCount_i == FIFO_DEPTH), w_txempty,
               (RxFifoCount_i == FIFO_DEPTH), (RxFifoCount_i == 16'd0)};
    case (RdAddr_i)
      3'd0:    w_rd_mux = r_imr;
      3'd1:    w_rd_mux = r_isr;
      3'd2:    w_rd_mux = IRQ_W'(w_state);
      3'd3:    w_rd_mux = IRQ_W'(RxFifoCount_i);
      3'd4:    w_rd_mux = IRQ_W'(TxFifoCount_i);
      default: w_rd_mux = '0;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      r_imr       <= '0;
      r_isr       <= '0;
      r_rd_data   <= '0;
      r_rd_valid  <= 1'b0;
      r_irq       <= 1'b0;
      r_cnt       <= '0;
      r_armed     <= 1'b0;
      r_rtrig_d   <= 1'b0;
      r_ttrig_d   <= 1'b1;
      r_txempty_d <= 1'b1;
    end else begin
      r_imr       <= w_imr_nxt;
      r_isr       <= w_isr_nxt;
      r_rd_valid  <= p_Re_i;
      if (p_Re_i) begin
        r_rd_data <= w_rd_mux;
      end
      r_irq       <= |(r_isr & r_imr);
      r_cnt       <= w_cnt_nxt;
      r_armed     <= w_armed_nxt;
      r_rtrig_d   <= w_rtrig;
      r_ttrig_d   <= w_ttrig;
      r_txempty_d <= w_txempty;
    end
  end

  assign RdData_o         = r_rd_data;
  assign p_RdValid_o      = r_rd_valid;
  assign InterruptMask_o  = r_imr;
  assign InterruptState_o = r_isr;
  assign p_Irq_o          = r_irq;

endmodule

// File: tb/tb_uart_irq_status.sv
// Directed self-checking bench for uart_irq_status with a read-data scoreboard.
module tb_uart_irq_status;

  logic        clk;
  logic        rst;
  logic        p_IerWe_i, p_IdrWe_i, p_IsrWe_i;
  logic [15:0] WrData_i;
  logic        p_Re_i;
  logic [2:0]  RdAddr_i;
  logic [15:0] RdData_o;
  logic        p_RdValid_o;
  logic [15:0] RxFifoCount_i, TxFifoCount_i, RxTriggerLevel_i, TxTriggerLevel_i;
  logic        p_RxByte_i, p_BitTick_i, p_RxOverflow_i, p_ParityErr_i, p_FrameErr_i;
  logic [15:0] InterruptMask_o, InterruptState_o;
  logic        p_Irq_o;

  int checks = 0;
  int failures = 0;
  logic [15:0] sb_q[$];

  uart_irq_status dut (
    .clk(clk), .rst(rst),
    .p_IerWe_i(p_IerWe_i), .p_IdrWe_i(p_IdrWe_i), .p_IsrWe_i(p_IsrWe_i),
    .WrData_i(WrData_i), .p_Re_i(p_Re_i), .RdAddr_i(RdAddr_i),
    .RdData_o(RdData_o), .p_RdValid_o(p_RdValid_o),
    .RxFifoCount_i(RxFifoCount_i), .TxFifoCount_i(TxFifoCount_i),
    .RxTriggerLevel_i(RxTriggerLevel_i), .TxTriggerLevel_i(TxTriggerLevel_i),
    .p_RxByte_i(p_RxByte_i), .p_BitTick_i(p_BitTick_i),
    .p_RxOverflow_i(p_RxOverflow_i), .p_ParityErr_i(p_ParityErr_i),
    .p_FrameErr_i(p_FrameErr_i),
    .InterruptMask_o(InterruptMask_o), .InterruptState_o(InterruptState_o),
    .p_Irq_o(p_Irq_o)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // One clock; inputs applied #1 after the edge, outputs sampled there too
  task automatic step();
    logic issued;
    issued = p_Re_i && rst;
    @(posedge clk);
    #1;
    chk("rd_valid", 16'(p_RdValid_o), 16'(issued));
    if (p_RdValid_o) begin
      if (sb_q.size() == 0) chk("sb_empty", 16'(sb_q.size()), 16'd1);
      else chk("rd_data", RdData_o, sb_q.pop_front());
    end
  endtask

  task automatic rd(input logic [2:0] addr, input logic [15:0] exp);
    p_Re_i = 1'b1;
    RdAddr_i = addr;
    if (rst) sb_q.push_back(exp);
    step();
    p_Re_i = 1'b0;
  endtask

  task automatic w1c(input logic [15:0] d);
    p_IsrWe_i = 1'b1;
    WrData_i = d;
    step();
    p_IsrWe_i = 1'b0;
    WrData_i = '0;
  endtask

  initial begin
    rst = 1'b0;
    {p_IerWe_i, p_IdrWe_i, p_IsrWe_i, p_Re_i} = '0;
    WrData_i = '0; RdAddr_i = '0;
    RxFifoCount_i = '0; TxFifoCount_i = '0;
    RxTriggerLevel_i = '0; TxTriggerLevel_i = '0;
    {p_RxByte_i, p_BitTick_i, p_RxOverflow_i, p_ParityErr_i, p_FrameErr_i} = '0;
    step(); step();
    chk("rst_imr", InterruptMask_o, 16'h0);
    chk("rst_isr", InterruptState_o, 16'h0);
    chk("rst_irq", 16'(p_Irq_o), 16'h0);
    chk("rst_rddata", RdData_o, 16'h0);
    rst = 1'b1;
    step();
    chk("post_rst_isr", InterruptState_o, 16'h0);

    // Reset-state reads
    rd(3'd0, 16'h0000);
    rd(3'd1, 16'h0000);
    rd(3'd2, 16'h0005);
    step();
    chk("rd_hold", RdData_o, 16'h0005);
    chk("irq_idle", 16'(p_Irq_o), 16'h0);

    // Parity event, masked-in, then cleared
    p_IerWe_i = 1'b1; WrData_i = 16'h0008; step(); p_IerWe_i = 1'b0; WrData_i = '0;
    chk("imr_ier", InterruptMask_o, 16'h0008);
    p_ParityErr_i = 1'b1; step(); p_ParityErr_i = 1'b0;
    chk("isr_pare", InterruptState_o, 16'h0008);
    chk("irq_lag", 16'(p_Irq_o), 16'h0);
    step();
    chk("irq_set", 16'(p_Irq_o), 16'h1);
    w1c(16'h0008);
    chk("isr_w1c", InterruptState_o, 16'h0);
    chk("irq_hold", 16'(p_Irq_o), 16'h1);
    step();
    chk("irq_clr", 16'(p_Irq_o), 16'h0);

    // Event beats clear; disable beats enable
    p_FrameErr_i = 1'b1; w1c(16'h0010); p_FrameErr_i = 1'b0;
    chk("isr_evt_wins", InterruptState_o, 16'h0010);
    w1c(16'h0010);
    chk("isr_frame_clr", InterruptState_o, 16'h0);
    p_IerWe_i = 1'b1; p_IdrWe_i = 1'b1; WrData_i = 16'h0001; step();
    p_IerWe_i = 1'b0; p_IdrWe_i = 1'b0; WrData_i = '0;
    chk("imr_idr_wins", InterruptMask_o, 16'h0008);
    rd(3'd0, 16'h0008);

    // RX trigger edge
    RxTriggerLevel_i = 16'd4; RxFifoCount_i = 16'd3; step();
    chk("rtrig_below", InterruptState_o, 16'h0);
    RxFifoCount_i = 16'd4; step();
    chk("rtrig_edge", InterruptState_o, 16'h0001);
    RxFifoCount_i = 16'd5; step();
    chk("rtrig_once", InterruptState_o, 16'h0001);
    rd(3'd2, 16'h0014);
    rd(3'd3, 16'h0005);
    rd(3'd4, 16'h0000);
    rd(3'd1, 16'h0001);
    w1c(16'h0001);
    step();
    chk("rtrig_no_retrig", InterruptState_o, 16'h0);

    // TX empty and TX trigger edges
    TxFifoCount_i = 16'd1; step();
    chk("txempty_fall", InterruptState_o, 16'h0);
    TxFifoCount_i = 16'd0; step();
    chk("txempty_edge", InterruptState_o, 16'h0020);
    w1c(16'h0020);
    TxTriggerLevel_i = 16'd2; TxFifoCount_i = 16'd5; step();
    chk("ttrig_above", InterruptState_o, 16'h0);
    TxFifoCount_i = 16'd1; step();
    chk("ttrig_edge", InterruptState_o, 16'h0002);
    TxTriggerLevel_i = 16'd0; w1c(16'h0002);
    chk("ttrig_clr", InterruptState_o, 16'h0);

    // RX timeout
    RxTriggerLevel_i = 16'd0; RxFifoCount_i = 16'd1; step();
    p_RxByte_i = 1'b1; step(); p_RxByte_i = 1'b0;
    for (int i = 1; i <= 32; i++) begin
      p_BitTick_i = 1'b1; step();
      if (i == 31) chk("tout_tick31", InterruptState_o, 16'h0);
    end
    p_BitTick_i = 1'b0;
    chk("tout_fire", InterruptState_o, 16'h0040);
    w1c(16'h0040);
    for (int i = 0; i < 40; i++) begin
      p_BitTick_i = 1'b1; step();
    end
    p_BitTick_i = 1'b0;
    chk("tout_no_retrig", InterruptState_o, 16'h0);
    p_RxByte_i = 1'b1; step(); p_RxByte_i = 1'b0;
    for (int i = 0; i < 30; i++) begin
      p_BitTick_i = 1'b1; step();
    end
    p_RxByte_i = 1'b1; step(); p_RxByte_i = 1'b0; p_BitTick_i = 1'b0;
    chk("tout_restart", InterruptState_o, 16'h0);
    rd(3'd2, 16'h0020);
    for (int i = 0; i < 31; i++) begin
      p_BitTick_i = 1'b1; step();
    end
    chk("tout_restart31", InterruptState_o, 16'h0);
    step();
    chk("tout_restart_fire", InterruptState_o, 16'h0040);
    p_BitTick_i = 1'b0;
    w1c(16'h0040);

    // Read of ISR: side effect only with the read-clear build
    p_RxOverflow_i = 1'b1; TxFifoCount_i = 16'd0; step(); p_RxOverflow_i = 1'b0;
    chk("isr_0024", InterruptState_o, 16'h0024);
    rd(3'd1, 16'h0024);
`ifdef ISR_READ_CLEAR_EN
    chk("isr_rdclr", InterruptState_o, 16'h0);
`else
    chk("isr_rd_noclr", InterruptState_o, 16'h0024);
`endif
    w1c(16'h007F);
    TxFifoCount_i = 16'd1; step();
    p_RxOverflow_i = 1'b1; TxFifoCount_i = 16'd0; step(); p_RxOverflow_i = 1'b0;
    p_RxOverflow_i = 1'b1; rd(3'd1, 16'h0024); p_RxOverflow_i = 1'b0;
`ifdef ISR_READ_CLEAR_EN
    chk("isr_rdclr_evt", InterruptState_o, 16'h0004);
`else
    chk("isr_rd_evt", InterruptState_o, 16'h0024);
`endif
    chk("irq_masked", 16'(p_Irq_o), 16'h0);

    // Reset during a read drops it
    p_Re_i = 1'b1; RdAddr_i = 3'd0; rst = 1'b0; step(); p_Re_i = 1'b0; rst = 1'b1;
    step();
    chk("mid_rst_imr", InterruptMask_o, 16'h0);
    chk("mid_rst_isr", InterruptState_o, 16'h0);
    chk("mid_rst_irq", 16'(p_Irq_o), 16'h0);
    chk("sb_drain", 16'(sb_q.size()), 16'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
